apb_uart_tx_periph: RTL and testbench
=====================================

// Module: apb_uart_tx_periph
// PURPOSE
//  APB slave UART transmitter. Hangs off the MCU APB master as an extra PSELn slot, beside the GPIO/FND peripherals.
//  CPU pushes bytes into a TX FIFO through APB writes.
//  An 8N1 serializer drains the FIFO onto txd at a programmable baud divider.
// PARAMETERS
//  FIFO_DEPTH   8        TX FIFO entries; power of 2, 2..16
//  BAUDDIV_RST  16'd867  BAUDDIV reset value; 100 MHz / 115200 -> 868 clocks per bit
// PORTS
//  PCLK     in   1   single clock; all logic on its rising edge
//  PRESET   in   1   asynchronous reset, active-low
//  PADDR    in   32  APB address; only PADDR[3:2] decoded
//  PWDATA   in   32  APB write data
//  PWRITE   in   1   1 = write, 0 = read
//  PENABLE  in   1   APB access phase
//  PSEL     in   1   slave select from APB master decoder
//  PRDATA   out  32  APB read data
//  PREADY   out  1   APB transfer complete
//  txd      out  1   serial output; idle high
// BEHAVIOUR
//  Reset (PRESET=0, async): txd=1, FIFO empty, BAUDDIV=BAUDDIV_RST, CTRL=0, OVF=0, FSM=IDLE, PRDATA=0.
//    PREADY=0 follows from PSEL=0.
//  APB timing
//    Zero wait states: PREADY = PSEL & PENABLE, combinational.
//    Writes commit on the clock edge where PSEL & PENABLE & PWRITE.
//    PRDATA is combinational from the registers while PSEL & !PWRITE; 0 otherwise.
//  Register map (offset; unlisted bits read 0)
//    0x0 TXDATA  W: push PWDATA[7:0] into FIFO. R: 0.
//    0x4 STATUS  R: [0]busy (FSM != IDLE), [1]full, [2]empty, [3]OVF, [8:4]count.
//                W: writing 1 to bit3 clears OVF; other bits ignored.
//    0x8 BAUDDIV RW [15:0]. Bit period = BAUDDIV+1 clocks. Value 0 is legal (1 clock/bit).
//    0xC CTRL    RW [0] en.
//  FIFO
//    Push when full: byte dropped, OVF set (sticky). Applies even if a pop occurs the same cycle.
//    Push and pop in the same cycle (not full): count unchanged, both take effect.
//    Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE
//    IDLE: txd=1. When en=1 & !empty: pop head into 8-bit shift reg, clear baud counter, go to START (txd=0 next cycle).
//    START: txd=0 for BAUDDIV+1 clocks, then go to DATA with bit index 0.
//    DATA: txd=shift[0], LSB first. Each bit lasts BAUDDIV+1 clocks. After bit 7, go to STOP.
//    STOP: txd=1 for BAUDDIV+1 clocks, then IDLE. The next byte can start on the following cycle.
//    Frame = 10*(BAUDDIV+1) clocks; 1 idle clock between back-to-back frames.
//    Baud counter counts 0..BAUDDIV; compares against the live BAUDDIV register.
//      Changing BAUDDIV mid-frame takes effect at the next compare.
//    en cleared mid-frame: current frame completes; no new pop.
//    Reset mid-frame: txd=1 immediately (async); the partial frame is abandoned.
// TESTING
//  1 Reset: drive PRESET=0 mid-frame -> txd=1 same cycle. STATUS reads 0x004 (empty). BAUDDIV reads 867.
//  2 Single byte: BAUDDIV=3, CTRL=1, write 0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks.
//    Total 40 clocks; busy=1 throughout; busy=0 after.
//  3 Back-to-back: BAUDDIV=0, CTRL=0, push 0x01,0x02,0x03, then CTRL=1 -> three 10-clock frames.
//    Gaps of 1 idle clock; count steps 3,2,1,0.
//  4 Overflow: CTRL=0, push 9 bytes (depth 8) -> full=1, count=8, OVF=1, 9th byte never sent.
//    Write 0x8 to STATUS -> OVF=0.
//  5 Disable mid-frame: 2 bytes queued, clear en during byte 1 data bits -> byte 1 completes.
//    txd stays 1; count=1, busy=0.
//  6 APB protocol: PSEL=1,PENABLE=0 write to TXDATA -> no push. PREADY=0 in setup, 1 in access.
//    Read of CTRL after writing 0xFFFFFFFF returns 0x1.

Source files
------------

// File: rtl/apb_uart_tx_periph.sv
// APB slave UART transmitter: CPU writes bytes into a TX FIFO, an 8N1 serializer
// drains them onto txd at a programmable bit period of BAUDDIV+1 clocks.
module apb_uart_tx_periph #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] BAUDDIV_RST = 16'd867
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PENABLE,
   input  logic        PSEL,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        txd
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // APB handshake: zero wait states, so a transfer completes in the access
   // phase (PSEL & PENABLE); writes commit on that edge, reads are combinational.
   logic        wr_access;
   logic [1:0]  reg_sel;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          push_ok;
   logic          pop;

   logic [15:0] bauddiv;
   logic        en;
   logic        ovf;

   tx_state_t   state;
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic [15:0] baud_cnt;
   logic        bit_end;
   logic        busy;
   logic [31:0] status;
   logic        unused_bits;

   assign wr_access = PSEL & PENABLE & PWRITE;
   assign reg_sel   = PADDR[3:2];
   assign PREADY    = PSEL & PENABLE;

   assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push    = wr_access && (reg_sel == 2'd0);
   assign push_ok = push & ~full;
   assign pop     = (state == IDLE) & en & ~empty;

   assign busy    = (state != IDLE);
   // Compare against the live divider; >= ends the bit promptly if BAUDDIV shrinks mid-bit.
   assign bit_end = (baud_cnt >= bauddiv);

   always_ff @(posedge PCLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= PWDATA[7:0];
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Overflow is sticky; a push while full is dropped even if a pop frees a slot that cycle.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         bauddiv <= BAUDDIV_RST;
         en      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (wr_access) begin
            case (reg_sel)
               2'd1: begin
                  if (PWDATA[3]) begin
                     ovf <= 1'b0;
                  end
               end
               2'd2:    bauddiv <= PWDATA[15:0];
               2'd3:    en      <= PWDATA[0];
               default: ;
            endcase
         end
         if (push & full) begin
            ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state    <= IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
         txd      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  baud_cnt <= '0;
                  txd      <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  txd      <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     txd     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               txd <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      status          = '0;
      status[0]       = busy;
      status[1]       = full;
      status[2]       = empty;
      status[3]       = ovf;
      status[4 +: CW] = count;
      PRDATA          = '0;
      if (PSEL && !PWRITE) begin
         case (reg_sel)
            2'd1:    PRDATA = status;
            2'd2:    PRDATA = {16'h0000, bauddiv};
            2'd3:    PRDATA = {31'h0, en};
            default: PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_uart_tx_periph.sv
// Bench for apb_uart_tx_periph: APB driver tasks, a FIFO/queue reference model and
// a serial-line monitor that decodes each 8N1 frame and checks bit values and widths.
module tb_apb_uart_tx_periph;

   localparam int DEPTH = 8;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PENABLE;
   logic        PSEL;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        txd;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   int         gap_q[$];
   int         tb_div   = 867;
   bit         mon_en   = 1'b0;
   bit         in_frame = 1'b0;
   bit         ovf_m    = 1'b0;
   int         cyc      = 0;
   int         last_end = 0;

   apb_uart_tx_periph #(.FIFO_DEPTH(DEPTH), .BAUDDIV_RST(16'd867)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PENABLE (PENABLE),
      .PSEL    (PSEL),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .txd     (txd)
   );

   always #5 PCLK = ~PCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_word(input bit busy, input int cnt, input bit ovf);
      logic [31:0] w;
      w    = 32'(cnt) << 4;
      w[0] = busy;
      w[1] = (cnt == DEPTH);
      w[2] = (cnt == 0);
      w[3] = ovf;
      return w;
   endfunction

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1 d = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      apb_write(32'h0, {24'h0, b});
      if (exp_q.size() >= DEPTH) ovf_m = 1'b1;
      else exp_q.push_back(b);
   endtask

   task automatic set_div(input int d);
      apb_write(32'h8, 32'(d));
      tb_div = d;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 4000) begin
         @(negedge PCLK);
         n++;
      end
      check_eq("drain_in_time", 32'(n < 4000), 32'd1);
      repeat (4) @(negedge PCLK);
   endtask

   task automatic wait_frame(input bit want, input string tag);
      int n = 0;
      while (in_frame != want && n < 1000) begin
         @(negedge PCLK);
         n++;
      end
      check_eq(tag, 32'(in_frame), 32'(want));
   endtask

   // Line monitor: a frame is start(0), 8 data bits LSB first, stop(1), each tb_div+1 clocks.
   initial begin : monitor
      logic [9:0] obs;
      logic [9:0] expv;
      logic [7:0] b;
      int         bad;
      forever begin
         @(negedge PCLK);
         cyc++;
         if (mon_en && PRESET && txd == 1'b0) begin
            in_frame = 1'b1;
            gap_q.push_back(cyc - last_end - 1);
            check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            expv = {1'b1, b, 1'b0};
            obs  = '0;
            bad  = 0;
            for (int k = 0; k < 10; k++) begin
               for (int j = 0; j <= tb_div; j++) begin
                  if (k != 0 || j != 0) begin
                     @(negedge PCLK);
                     cyc++;
                  end
                  if (j == 0) obs[k] = txd;
                  else if (txd !== obs[k]) bad++;
               end
            end
            last_end = cyc;
            check_eq("frame_bits", 32'(obs), 32'(expv));
            check_eq("bit_hold", 32'(bad), 32'd0);
            in_frame = 1'b0;
         end
      end
   end

   initial begin : main
      logic [31:0] rd;
      int          n;
      PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(negedge PCLK);
      check_eq("rst_txd", 32'(txd), 32'd1);
      check_eq("rst_pready", 32'(PREADY), 32'd0);
      check_eq("rst_prdata", PRDATA, 32'd0);
      PRESET = 1'b1;
      mon_en = 1'b1;
      apb_read(32'h4, rd); check_eq("rst_status", rd, 32'h4);
      apb_read(32'h8, rd); check_eq("rst_bauddiv", rd, 32'd867);
      apb_read(32'hC, rd); check_eq("rst_ctrl", rd, 32'd0);

      // APB protocol corner cases
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h5A; PENABLE = 1'b0;
      #1 check_eq("pready_setup", 32'(PREADY), 32'd0);
      repeat (2) @(negedge PCLK);
      PSEL = 1'b0; PWRITE = 1'b0;
      apb_read(32'h4, rd); check_eq("setup_no_push", rd, 32'h4);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'hC; PENABLE = 1'b0;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1 check_eq("pready_access", 32'(PREADY), 32'd1);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      apb_write(32'hC, 32'hFFFF_FFFF);
      apb_read(32'hC, rd); check_eq("ctrl_mask", rd, 32'h1);
      apb_write(32'hC, 32'h0);
      apb_write(32'h8, 32'hABCD_1234);
      apb_read(32'h8, rd); check_eq("bauddiv_mask", rd, 32'h1234);

      // Single byte at 4 clocks per bit
      set_div(3);
      apb_write(32'hC, 32'h1);
      push(8'hA5);
      apb_read(32'h4, rd); check_eq("busy_mid_frame", rd & 32'h1, 32'h1);
      wait_drain();
      apb_read(32'h4, rd); check_eq("idle_after_single", rd, status_word(0, 0, 0));

      // Back-to-back frames at 1 clock per bit
      apb_write(32'hC, 32'h0);
      set_div(0);
      push(8'h01); push(8'h02); push(8'h03);
      apb_read(32'h4, rd); check_eq("count_three", rd, status_word(0, 3, 0));
      gap_q.delete();
      apb_write(32'hC, 32'h1);
      wait_drain();
      check_eq("b2b_frames", 32'(gap_q.size()), 32'd3);
      if (gap_q.size() == 3) begin
         check_eq("b2b_gap1", 32'(gap_q[1]), 32'd1);
         check_eq("b2b_gap2", 32'(gap_q[2]), 32'd1);
      end
      apb_read(32'h4, rd); check_eq("b2b_empty", rd, status_word(0, 0, 0));

      // Overflow: nine pushes into eight entries
      apb_write(32'hC, 32'h0);
      for (int i = 0; i < 9; i++) push(8'($urandom_range(0, 255)));
      apb_read(32'h4, rd); check_eq("ovf_full", rd, status_word(0, 8, ovf_m));
      apb_write(32'h4, 32'hF7);
      apb_read(32'h4, rd); check_eq("ovf_sticky", rd, status_word(0, 8, ovf_m));
      apb_write(32'h4, 32'h8);
      ovf_m = 1'b0;
      apb_read(32'h4, rd); check_eq("ovf_clear", rd, status_word(0, 8, ovf_m));
      set_div(1);
      apb_write(32'hC, 32'h1);
      wait_drain();
      apb_read(32'h4, rd); check_eq("ovf_drained", rd, status_word(0, 0, 0));

      // Disable during the first frame's data bits
      apb_write(32'hC, 32'h0);
      set_div(3);
      push(8'h3C); push(8'hC3);
      apb_write(32'hC, 32'h1);
      wait_frame(1'b1, "dis_frame_start");
      repeat (8) @(negedge PCLK);
      apb_write(32'hC, 32'h0);
      wait_frame(1'b0, "dis_frame_end");
      repeat (20) @(negedge PCLK);
      check_eq("dis_second_held", 32'(exp_q.size()), 32'd1);
      check_eq("dis_txd_idle", 32'(txd), 32'd1);
      apb_read(32'h4, rd); check_eq("dis_status", rd, status_word(0, 1, 0));
      apb_write(32'hC, 32'h1);
      wait_drain();
      apb_write(32'hC, 32'h0);

      // Randomized rounds: random divider, burst length and data
      for (int r = 0; r < 6; r++) begin
         set_div($urandom_range(0, 4));
         n = $urandom_range(1, 11);
         for (int i = 0; i < n; i++) begin
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
               apb_read(32'h4, rd); check_eq("rnd_status", rd, status_word(0, exp_q.size(), ovf_m));
            end
         end
         apb_read(32'h4, rd); check_eq("rnd_loaded", rd, status_word(0, exp_q.size(), ovf_m));
         if (ovf_m) begin
            apb_write(32'h4, 32'h8);
            ovf_m = 1'b0;
         end
         apb_write(32'hC, 32'h1);
         wait_drain();
         apb_read(32'h4, rd); check_eq("rnd_drained", rd, status_word(0, 0, 0));
         apb_write(32'hC, 32'h0);
      end

      // Asynchronous reset in the middle of a frame
      mon_en = 1'b0;
      set_div(3);
      apb_write(32'hC, 32'h1);
      apb_write(32'h0, 32'h00);
      n = 0;
      while (txd !== 1'b0 && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      repeat (6) @(negedge PCLK);
      check_eq("txd_low_before_rst", 32'(txd), 32'd0);
      #2 PRESET = 1'b0;
      #1 check_eq("rst_async_txd", 32'(txd), 32'd1);
      @(negedge PCLK);
      PRESET = 1'b1;
      tb_div = 867;
      apb_read(32'h4, rd); check_eq("rst2_status", rd, 32'h4);
      apb_read(32'h8, rd); check_eq("rst2_bauddiv", rd, 32'd867);
      apb_read(32'hC, rd); check_eq("rst2_ctrl", rd, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
